// File: rtl/gh_uart_rx_deframer_if.sv
// Received-word bus from the UART receive deframer to the receive FIFO.
// The master drives a one-cycle rdy strobe with word and status.
interface gh_uart_rx_deframer_if;
    logic [7:0] d;
    logic       rdy;
    logic       pe;
    logic       fe;
    logic       brk;

    modport master (output d, rdy, pe, fe, brk);
    modport slave  (input  d, rdy, pe, fe, brk);
endinterface

// File: rtl/gh_uart_rx_deframer.sv
// UART serial receive deframer: 16x oversampled start qualification, 5-8 data
// bits LSB first, optional parity, stop check, break detect.
module gh_uart_rx_deframer (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          srst,
    input  logic                          brc,
    input  logic                          sin,
    input  logic [1:0]                    num_bits,
    input  logic                          parity_en,
    input  logic                          parity_ev,
    output logic                          busy,
    gh_uart_rx_deframer_if.master         rx
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       sync1_q, sync1_d;
    logic       sin_s_q, sin_s_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic       acc_q, acc_d;
    logic [7:0] sh_q, sh_d;
    logic       par_bit_q, par_bit_d;
    logic [1:0] nb_q, nb_d;
    logic       pen_q, pen_d;
    logic       pev_q, pev_d;
    logic [7:0] d_q, d_d;
    logic       rdy_q, rdy_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       brk_q, brk_d;

    logic       mid;
    logic       wrap;
    logic [2:0] last_bcnt;
    logic [1:0] shamt;
    logic [7:0] word;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sin_s_q   <= 1'b1;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            acc_q     <= 1'b0;
            sh_q      <= '0;
            par_bit_q <= 1'b0;
            nb_q      <= '0;
            pen_q     <= 1'b0;
            pev_q     <= 1'b0;
            d_q       <= '0;
            rdy_q     <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sin_s_q   <= sin_s_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            par_bit_q <= par_bit_d;
            nb_q      <= nb_d;
            pen_q     <= pen_d;
            pev_q     <= pev_d;
            d_q       <= d_d;
            rdy_q     <= rdy_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            brk_q     <= brk_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d   = state_q;
        sync1_d   = sin;
        sin_s_d   = sync1_q;
        cnt_d     = cnt_q;
        bcnt_d    = bcnt_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        par_bit_d = par_bit_q;
        nb_d      = nb_q;
        pen_d     = pen_q;
        pev_d     = pev_q;
        d_d       = d_q;
        rdy_d     = 1'b0;
        pe_d      = pe_q;
        fe_d      = fe_q;
        brk_d     = brk_q;

        mid       = brc && (cnt_q == 4'd7);
        wrap      = brc && (cnt_q == 4'd15);
        // Value bcnt holds after the last data bit; length 8 wraps to 0.
        last_bcnt = 3'd5 + {1'b0, nb_q};
        shamt     = 2'd3 - nb_q;
        word      = sh_q >> shamt;

        if (brc && state_q != IDLE && state_q != WAIT_HI)
            cnt_d = cnt_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (brc && !sin_s_q) begin
                    cnt_d   = 4'd1;
                    acc_d   = 1'b0;
                    bcnt_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (mid && sin_s_q) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    nb_d    = num_bits;
                    pen_d   = parity_en;
                    pev_d   = parity_ev;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (mid) begin
                    sh_d   = {sin_s_q, sh_q[7:1]};
                    acc_d  = acc_q ^ sin_s_q;
                    bcnt_d = bcnt_q + 3'd1;
                end
                if (wrap && bcnt_q == last_bcnt)
                    state_d = pen_q ? PARITY : STOP;
            end
            PARITY: begin
                if (mid) begin
                    acc_d     = acc_q ^ sin_s_q;
                    par_bit_d = sin_s_q;
                end
                if (wrap)
                    state_d = STOP;
            end
            STOP: begin
                if (mid) begin
                    d_d     = word;
                    pe_d    = pen_q & (acc_q ^ ~pev_q);
                    fe_d    = ~sin_s_q;
                    brk_d   = ~sin_s_q & (word == 8'h00) & (~pen_q | ~par_bit_q);
                    rdy_d   = 1'b1;
                    state_d = sin_s_q ? IDLE : WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (sin_s_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (srst) begin
            state_d   = IDLE;
            sync1_d   = 1'b1;
            sin_s_d   = 1'b1;
            cnt_d     = '0;
            bcnt_d    = '0;
            acc_d     = 1'b0;
            sh_d      = '0;
            par_bit_d = 1'b0;
            nb_d      = '0;
            pen_d     = 1'b0;
            pev_d     = 1'b0;
            d_d       = '0;
            rdy_d     = 1'b0;
            pe_d      = 1'b0;
            fe_d      = 1'b0;
            brk_d     = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        busy   = (state_q != IDLE);
        rx.d   = d_q;
        rx.rdy = rdy_q;
        rx.pe  = pe_q;
        rx.fe  = fe_q;
        rx.brk = brk_q;
    end

endmodule

// File: tb/tb_gh_uart_rx_deframer.sv
// Directed bench for gh_uart_rx_deframer: frames are driven bit by bit with
// brc high every clock; a monitor checks each rdy against a queue of expected words.
module tb_gh_uart_rx_deframer;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       srst;
    logic       brc;
    logic       sin;
    logic [1:0] num_bits;
    logic       parity_en;
    logic       parity_ev;
    logic       busy;

    gh_uart_rx_deframer_if rx_if ();

    gh_uart_rx_deframer dut (
        .clk       (clk),
        .rst       (rst),
        .srst      (srst),
        .brc       (brc),
        .sin       (sin),
        .num_bits  (num_bits),
        .parity_en (parity_en),
        .parity_ev (parity_ev),
        .busy      (busy),
        .rx        (rx_if)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   rdy_cnt = 0;
    int   base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every rdy pulse consumes one expected word.
    always @(negedge clk) begin
        if (rx_if.rdy === 1'b1) begin
            exp_t e;
            rdy_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdy: got d=0x%02h expected no rdy at %0t", rx_if.d, $time);
            end else begin
                e = exp_q.pop_front();
                check("d",   rx_if.d,         e.d);
                check("pe",  8'(rx_if.pe),    8'(e.pe));
                check("fe",  8'(rx_if.fe),    8'(e.fe));
                check("brk", 8'(rx_if.brk),   8'(e.brk));
            end
        end
    end

    task automatic expect_word(input logic [7:0] d, input logic pe, input logic fe, input logic brk);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe; e.brk = brk;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        repeat (16) @(negedge clk);
    endtask

    // Stop bit value is left on the line afterwards; the caller releases it.
    task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                              input logic pev, input logic par_bit, input logic stop_val);
        num_bits  = 2'(nbits - 5);
        parity_en = pen;
        parity_ev = pev;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (pen) send_bit(par_bit);
        send_bit(stop_val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; srst = 1'b0; brc = 1'b1; sin = 1'b1;
        num_bits = 2'b11; parity_en = 1'b0; parity_ev = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_d",    rx_if.d,         8'h00);
        check("rst_rdy",  8'(rx_if.rdy),   8'h00);
        check("rst_pe",   8'(rx_if.pe),    8'h00);
        check("rst_fe",   8'(rx_if.fe),    8'h00);
        check("rst_brk",  8'(rx_if.brk),   8'h00);
        check("rst_busy", 8'(busy),        8'h00);

        // 8N1 0xA5
        expect_word(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("busy_after_8n1", 8'(busy), 8'h00);

        // 7E1 0x35 (four ones): parity bit 1 is wrong, 0 is right
        expect_word(8'h35, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_word(8'h35, 1'b0, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1);

        // 5O1 0x1F (five ones, parity 0) with a bad stop bit, then 5O1 0x0A
        expect_word(8'h1F, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("busy_wait_hi", 8'(busy), 8'h01);
        sin = 1'b1;
        repeat (8) @(negedge clk);
        check("busy_wait_hi_exit", 8'(busy), 8'h00);
        expect_word(8'h0A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h0A, 5, 1'b1, 1'b0, 1'b1, 1'b1);

        // Line held low for three 8N1 frame times: one break frame only
        num_bits = 2'b11; parity_en = 1'b0;
        base = rdy_cnt;
        expect_word(8'h00, 1'b0, 1'b1, 1'b1);
        sin = 1'b0;
        repeat (480) @(negedge clk);
        check("busy_held_low", 8'(busy), 8'h01);
        check_int("rdy_held_low", rdy_cnt, base + 1);
        sin = 1'b1;
        repeat (40) @(negedge clk);
        check_int("rdy_after_release", rdy_cnt, base + 1);
        expect_word(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // Four-brc glitch: start rejected at mid-bit check
        base = rdy_cnt;
        sin = 1'b0;
        repeat (4) @(negedge clk);
        sin = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_glitch", 8'(busy), 8'h01);
        repeat (20) @(negedge clk);
        check("busy_after_glitch", 8'(busy), 8'h00);
        check_int("rdy_glitch", rdy_cnt, base);

        // Async reset in the middle of DATA of 0x5A
        base = rdy_cnt;
        num_bits = 2'b11; parity_en = 1'b0;
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        sin = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_d",    rx_if.d,        8'h00);
        check("mid_rst_rdy",  8'(rx_if.rdy),  8'h00);
        check("mid_rst_fe",   8'(rx_if.fe),   8'h00);
        check("mid_rst_busy", 8'(busy),       8'h00);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_int("rdy_mid_rst", rdy_cnt, base);
        expect_word(8'hC3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        check_int("pending_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
